// File: rtl/core_mem_arbiter.sv
// ============================================================================
// core_mem_arbiter: fetch/data port arbiter onto one single-port memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_mem_arbiter #(
  parameter int TIMEOUT     = 16,
  parameter int D_BURST_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_ack_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_unsigned_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int BW = $clog2(D_BURST_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic [BW-1:0] burst_q;
  logic [TW-1:0] tcnt_q;
  logic        sel_d_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        i_ack_q, i_err_q, d_ack_q, d_err_q;
  logic [31:0] i_rdata_q, d_rdata_q;

  logic        pick_d, pick_i, mis_d, mis_i;
  logic [3:0]  req_be;
  logic [31:0] req_wdata, shifted, load_word;
  logic [BW-1:0] burst_inc;

  always_comb begin
    pick_d    = d_req_i && (!i_req_i || (burst_q != BW'(D_BURST_MAX)));
    pick_i    = i_req_i && !pick_d;
    mis_i     = (i_addr_i[1:0] != 2'b00);
    burst_inc = (burst_q == BW'(D_BURST_MAX)) ? burst_q : burst_q + 1'b1;
    case (d_size_i)
      2'd0: begin
        mis_d     = 1'b0;
        req_be    = 4'b0001 << d_addr_i[1:0];
        req_wdata = {4{d_wdata_i[7:0]}};
      end
      2'd1: begin
        mis_d     = d_addr_i[0];
        req_be    = 4'b0011 << d_addr_i[1:0];
        req_wdata = {2{d_wdata_i[15:0]}};
      end
      2'd2: begin
        mis_d     = (d_addr_i[1:0] != 2'b00);
        req_be    = 4'b1111;
        req_wdata = d_wdata_i;
      end
      default: begin
        mis_d     = 1'b1;
        req_be    = 4'b1111;
        req_wdata = d_wdata_i;
      end
    endcase
    if (!d_we_i) req_be = 4'b1111;

    // Lane select uses latched offset; aligned words have offset 0.
    shifted = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_word = {{24{!uns_q && shifted[7]}}, shifted[7:0]};
      2'd1:    load_word = {{16{!uns_q && shifted[15]}}, shifted[15:0]};
      default: load_word = shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      burst_q     <= '0;
      tcnt_q      <= '0;
      sel_d_q     <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_d || pick_i) begin
            sel_d_q     <= pick_d;
            off_q       <= pick_d ? d_addr_i[1:0] : i_addr_i[1:0];
            size_q      <= pick_d ? d_size_i : 2'd2;
            uns_q       <= d_unsigned_i;
            mem_addr_q  <= pick_d ? {d_addr_i[31:2], 2'b00} : {i_addr_i[31:2], 2'b00};
            mem_be_q    <= pick_d ? req_be : 4'b1111;
            mem_wdata_q <= pick_d ? req_wdata : '0;
            tcnt_q      <= '0;
            if (pick_i)
              burst_q <= '0;
            else if (i_req_i)
              burst_q <= burst_inc;
            if (pick_d ? mis_d : mis_i) begin
              state_q <= S_RESP;
              if (pick_d) begin
                d_ack_q   <= 1'b1;
                d_err_q   <= 1'b1;
                d_rdata_q <= '0;
              end else begin
                i_ack_q   <= 1'b1;
                i_err_q   <= 1'b1;
                i_rdata_q <= '0;
              end
            end else begin
              state_q   <= S_ACCESS;
              mem_req_q <= 1'b1;
              mem_we_q  <= pick_d && d_we_i;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready_i || (tcnt_q == TW'(TIMEOUT - 1))) begin
            state_q   <= S_RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (sel_d_q) begin
              d_ack_q   <= 1'b1;
              d_err_q   <= !mem_ready_i;
              d_rdata_q <= (mem_ready_i && !mem_we_q) ? load_word : '0;
            end else begin
              i_ack_q   <= 1'b1;
              i_err_q   <= !mem_ready_i;
              i_rdata_q <= mem_ready_i ? load_word : '0;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i_ack_o     = i_ack_q;
  assign i_rdata_o   = i_rdata_q;
  assign i_err_o     = i_err_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
// ============================================================================
// tb_core_mem_arbiter: directed vectors with hand-computed expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_unsigned, d_ack, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(.TIMEOUT(16), .D_BURST_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_ack_o(i_ack), .i_rdata_o(i_rdata), .i_err_o(i_err),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_size_i(d_size),
    .d_unsigned_i(d_unsigned), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic d_setup(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd);
    d_req = 1'b1; d_addr = a; d_we = we; d_size = sz; d_unsigned = uns; d_wdata = wd;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0; d_we = 1'b0;
    d_size = 2'd0; d_unsigned = 1'b0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be_we", {27'd0, mem_be, mem_we}, 32'd0);

    // Fetch, memory ready in the first access cycle
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h00500093;
    step();
    check("i_c1_mem_req", 32'(mem_req), 32'd1);
    check("i_c1_mem_addr", mem_addr, 32'h100);
    check("i_c1_be_we", {27'd0, mem_be, mem_we}, {27'd0, 4'b1111, 1'b0});
    check("i_c1_ack", 32'(i_ack), 32'd0);
    step();
    check("i_c2_ack", {30'd0, i_ack, d_ack}, 32'd2);
    check("i_c2_rdata", i_rdata, 32'h00500093);
    check("i_c2_err", 32'(i_err), 32'd0);
    check("i_c2_mem_req", 32'(mem_req), 32'd0);
    i_req = 1'b0;
    step();
    check("i_c3_ack", 32'(i_ack), 32'd0);

    // Byte store to lane 3
    mem_ready = 1'b0;
    d_setup(32'h203, 1'b1, 2'd0, 1'b0, 32'h000000AB);
    step();
    check("sb_mem_req", 32'(mem_req), 32'd1);
    check("sb_mem_addr", mem_addr, 32'h200);
    check("sb_mem_be", 32'(mem_be), 32'h8);
    check("sb_mem_wdata", mem_wdata, 32'hABABABAB);
    check("sb_mem_we", 32'(mem_we), 32'd1);
    mem_ready = 1'b1;
    step();
    check("sb_ack", {30'd0, i_ack, d_ack}, 32'd1);
    check("sb_rdata_err", {d_rdata[30:0], d_err}, 32'd0);
    d_req = 1'b0;
    step();

    // Signed then unsigned halfword load from upper lane
    mem_rdata = 32'h8001FFFF;
    d_setup(32'h202, 1'b0, 2'd1, 1'b0, 32'h0);
    step();
    check("lh_be_we", {27'd0, mem_be, mem_we}, {27'd0, 4'b1111, 1'b0});
    step();
    check("lh_ack", 32'(d_ack), 32'd1);
    check("lh_rdata", d_rdata, 32'hFFFF8001);
    d_req = 1'b0;
    step();
    d_setup(32'h202, 1'b0, 2'd1, 1'b1, 32'h0);
    step(); step();
    check("lhu_rdata", d_rdata, 32'h00008001);
    d_req = 1'b0;
    step();

    // Signed byte load from lane 1
    mem_rdata = 32'h12348056;
    d_setup(32'h201, 1'b0, 2'd0, 1'b0, 32'h0);
    step(); step();
    check("lb_rdata", d_rdata, 32'hFFFFFF80);
    d_req = 1'b0;
    step();

    // Misaligned data word and misaligned fetch
    d_setup(32'h301, 1'b0, 2'd2, 1'b0, 32'h0);
    step();
    check("mis_d_ack_err", {30'd0, d_ack, d_err}, 32'd3);
    check("mis_d_rdata", d_rdata, 32'd0);
    check("mis_d_mem_req", 32'(mem_req), 32'd0);
    d_req = 1'b0;
    step();
    i_req = 1'b1; i_addr = 32'h102;
    step();
    check("mis_i_ack_err", {30'd0, i_ack, i_err}, 32'd3);
    check("mis_i_mem_req", 32'(mem_req), 32'd0);
    i_req = 1'b0;
    step();

    // Timeout: 16 access cycles without ready
    mem_ready = 1'b0; i_req = 1'b1; i_addr = 32'h104;
    step();
    repeat (15) step();
    check("to_c16_req_ack", {30'd0, mem_req, i_ack}, 32'd2);
    step();
    check("to_c17_ack_err", {30'd0, i_ack, i_err}, 32'd3);
    check("to_c17_rdata", i_rdata, 32'd0);
    check("to_c17_mem_req", 32'(mem_req), 32'd0);
    i_req = 1'b0;
    step();

    // Reset during an access
    d_setup(32'h400, 1'b0, 2'd2, 1'b0, 32'h0);
    step();
    check("rsta_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    check("rsta_after", {29'd0, mem_req, d_ack, i_ack}, 32'd0);
    rst = 1'b0; d_req = 1'b0;
    step(); step();
    check("rsta_no_ack", {30'd0, d_ack, i_ack}, 32'd0);

    // Both requesters held: D,D,D,D,I repeating
    mem_ready = 1'b1; mem_rdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h600;
    d_setup(32'h500, 1'b0, 2'd2, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      step(); step();
      check($sformatf("arb_%0d_acks", k), {30'd0, i_ack, d_ack},
            ((k % 5) == 4) ? 32'd2 : 32'd1);
      step();
      check($sformatf("arb_%0d_idle", k), {30'd0, i_ack, d_ack}, 32'd0);
    end
    i_req = 1'b0; d_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001: Parameter TIMEOUT, default 16: max cycles in ACCESS awaiting MEM_READY before abort.
REQ-002: Parameter D_BURST_MAX, default 4: max consecutive D grants while I_REQ pending.
REQ-003: CLK  in  1  sole clock; all state updates on rising edge.
REQ-004: RST  in  1  synchronous, active-high reset.
REQ-005: I_REQ  in  1  fetch request; held until I_ACK.
REQ-006: I_ADDR  in  32  fetch byte address.
REQ-007: I_ACK  out  1  one-cycle fetch completion pulse.
REQ-008: I_RDATA  out  32  fetched word; valid when I_ACK=1.
REQ-009: I_ERR  out  1  fetch error (misaligned or timeout); valid when I_ACK=1.
REQ-010: D_REQ  in  1  load/store request; held until D_ACK.
REQ-011: D_ADDR  in  32  data byte address.
REQ-012: D_WE  in  1  1=store, 0=load.
REQ-013: D_SIZE  in  2  0=byte, 1=half, 2=word; 3 treated as misaligned.
REQ-014: D_UNSIGNED  in  1  zero-extend load when 1, sign-extend when 0.
REQ-015: D_WDATA  in  32  store data, right-aligned.
REQ-016: D_ACK  out  1  one-cycle data completion pulse.
REQ-017: D_RDATA  out  32  aligned, extended load data; valid when D_ACK=1.
REQ-018: D_ERR  out  1  data error (misaligned or timeout); valid when D_ACK=1.
REQ-019: MEM_REQ  out  1  access request to shared single-port memory.
REQ-020: MEM_ADDR  out  32  word address {addr[31:2],2'b00}.
REQ-021: MEM_WE  out  1  write enable.
REQ-022: MEM_BE  out  4  byte enables.
REQ-023: MEM_WDATA  out  32  write data, lane-replicated.
REQ-024: MEM_RDATA  in  32  read word; valid when MEM_READY=1.
REQ-025: MEM_READY  in  1  access complete this cycle (may assert in first MEM_REQ cycle).

Function
REQ-026: FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on grant, ACCESS->RESP on MEM_READY or timeout, RESP->IDLE unconditionally.
REQ-027: Requests sampled only in IDLE; winner's address/control/data latched on grant; ACCESS drives memory from latched values only.
REQ-028: Arbitration: D wins when both pending, unless D burst counter = D_BURST_MAX, then I wins.
REQ-029: D burst counter increments on each D grant made while I_REQ=1, clears on any I grant, saturates at D_BURST_MAX.
REQ-030: Misaligned D (half with addr[0]=1, word with addr[1:0]!=0, size 3) or I (addr[1:0]!=0): no MEM_REQ; IDLE->RESP directly, ACK with ERR=1, RDATA=0.
REQ-031: MEM_REQ=1 exactly while in ACCESS; MEM_WE=latched D_WE for D grant, 0 for I grant.
REQ-032: MEM_BE: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word or any read 4'b1111.
REQ-033: MEM_WDATA: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-034: Load data: select byte/half lane by addr[1:0] from MEM_RDATA, sign- or zero-extend to 32 bits per D_UNSIGNED; word passes through.
REQ-035: Read data registered on MEM_READY and presented in RESP; stores return RDATA=0.
REQ-036: Timeout counter clears on ACCESS entry; at TIMEOUT cycles without MEM_READY -> RESP with ERR=1, RDATA=0.
REQ-037: Latency: request seen in IDLE cycle 0, MEM_READY in first ACCESS cycle -> ACK in cycle 2; each wait cycle adds one.
REQ-038: ACK pulses exactly one cycle in RESP to the granted requester only; a REQ still high after ACK is a new request.
REQ-039: Requests changing while not granted are ignored until next IDLE.

Reset
REQ-040: RST=1: state IDLE, burst and timeout counters 0, all outputs 0 next edge, including mid-ACCESS (access dropped, no ACK).

Verification
REQ-041: I_REQ addr 0x100, MEM_READY same cycle, MEM_RDATA 0x00500093 -> I_ACK cycle 2, I_RDATA 0x00500093, I_ERR=0.
REQ-042: D store byte addr 0x203 wdata 0x000000AB -> MEM_ADDR 0x200, MEM_BE 4'b1000, MEM_WDATA 0xABABABAB, MEM_WE=1.
REQ-043: D load half signed addr 0x202, MEM_RDATA 0x8001FFFF -> D_RDATA 0xFFFF8001; same unsigned -> 0x00008001.
REQ-044: I_REQ and D_REQ held continuously -> grants D,D,D,D,I repeating; no I fetch starved beyond 4 D grants.
REQ-045: D word load addr 0x301 -> no MEM_REQ, D_ACK cycle 1 with D_ERR=1; MEM_READY held 0 on valid access -> ACK with ERR after 16 ACCESS cycles.
REQ-046: RST asserted in ACCESS with MEM_READY=0 -> next cycle IDLE, MEM_REQ=0, no ACK issued.
